cmd_treat_param: RTL
====================

// Module: cmd_treat_param
// PURPOSE
//  Parametrised successor command-record reader between the BPI flash reader and the config command parser.
//  Unpacks flash words into bytes (optional per-byte bit reversal) and buffers them in an internal FIFO.
//  Streams fixed-length records out with valid/ready backpressure.
//  Checks each record (status byte, record count, version, checksum) and reports reconfig status AA/55.
// PARAMETERS
//  IN_BYTES     2      bytes per flash word, >=1; MSB byte first
//  REC_LEN      256    bytes per record, 16..1024
//  FIFO_DEPTH   512    internal byte FIFO depth, power of 2, >= REC_LEN
//  BIT_REV      1      1: reverse bit order within each byte; 0: pass through
//  CHK_EN       1      1: last record byte is checksum; sum of all REC_LEN bytes mod 256 must be 0
//  MAX_STAT     6      highest legal status byte value
// PORTS
//  clk                 in   1            single clock
//  rst                 in   1            synchronous, active-high reset
//  reconfig_data       in   8*IN_BYTES   flash word
//  reconfig_data_en    in   1            word strobe, one cycle
//  bpi_idle            in   1            flash reader idle; record drain may start
//  config_valid        in   1            level; rising edge requests a read
//  reconfig_read_start out  1            1-cycle pulse: start flash read
//  reconfig_read_end   out  1            1-cycle pulse: stop flash read
//  con_dout            out  8            record byte
//  con_dout_en         out  1            con_dout valid
//  con_dout_rdy        in   1            downstream ready; transfer = en & rdy
//  reconfig_status     out  8            00 none, AA success, 55 fail
//  reconfig_version1   out  8            version taken from first record
//  rec_cnt             out  16           records drained since reset/start
//  buf_overflow        out  1            1-cycle pulse: input byte dropped
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO flushed; FSM to IDLE. Reset mid-drain aborts the record and reports no status.
//  - Unpack: strobe latches the word; bytes are written MSB first, one per cycle, over IN_BYTES cycles.
//    A strobe during serialisation, or a write to a full FIFO, drops the data and pulses buf_overflow.
//  - config_valid rising edge is latched and serviced in IDLE. A second edge while pending merges.
//  - FSM:
//    IDLE  -> START  when an edge is pending. This has priority.
//    IDLE  -> DRAIN  when FIFO count >= REC_LEN and bpi_idle.
//    START -> IDLE   after 1 cycle.
//      reconfig_read_start pulses on the next cycle.
//      reconfig_status, rec_cnt and reconfig_version1 clear to 0.
//    DRAIN: on entry rec_cnt += 1 (16-bit wrap); the byte index k starts at 0.
//      The first con_dout_en is asserted on the cycle after entry. Holds while rdy=0.
//      k advances per transfer. After transfer k=REC_LEN-1 -> CHECK.
//    CHECK -> IDLE   after 1 cycle.
//  - Per-record checks on transferred bytes:
//    k=3: stat. stat==0 marks an end record. stat>MAX_STAT sets fail.
//    k=4: byte > stat sets fail.
//    rec_cnt==1: k=6,7 -> expected count (big-endian 16b). k=8 -> reconfig_version1.
//    End record: k=6 -> version2.
//    CHK_EN: a running 8-bit sum is kept. A nonzero sum after k=REC_LEN-1 sets fail.
//  - reconfig_read_end pulses 1 cycle after the k=3 transfer if stat==0 or stat>MAX_STAT.
//    It also pulses 1 cycle after the k=4 transfer if byte > stat. At most one pulse per record.
//  - CHECK, evaluated in this order:
//    fail -> status 55.
//    End record: expected+1==rec_cnt (mod 2^16) and version1==version2 -> AA, else 55.
//    Otherwise status is unchanged.
//    Status is updated on the cycle after CHECK and holds until reset or START.
//  - A flash write during DRAIN continues into the FIFO. A config_valid edge during DRAIN waits for IDLE.
// TESTING
//  - Reset, then config_valid 0->1 -> reconfig_read_start high for exactly 1 cycle; status 00.
//  - Word 16'h8001, BIT_REV=1 -> FIFO bytes 01 then 80. Strobe on the next cycle -> buf_overflow pulse.
//  - Record 1 (stat 3, count 0x0002, ver 0x17), record 2 (stat 5), record 3 (stat 0, ver 0x17), valid checksums
//    -> reconfig_version1=17; read_end after record-3 k=3; status AA; rec_cnt 3.
//  - As above with record-3 ver 0x18 -> 55. Separately, any record with stat 7 -> read_end pulse, 55.
//  - con_dout_rdy toggled randomly during drain -> bytes in order, none lost or duplicated, REC_LEN transfers.
//  - Corrupted checksum byte in a non-end record -> 55 after CHECK. Reset mid-drain -> status 00, FIFO empty.

Source files
------------

// File: rtl/cmd_treat_param.sv
// cmd_treat_param: unpacks flash words into a byte FIFO and streams, checks and reports fixed-length command records
module cmd_treat_param #(
  parameter int IN_BYTES   = 2,
  parameter int REC_LEN    = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int BIT_REV    = 1,
  parameter int CHK_EN     = 1,
  parameter int MAX_STAT   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*IN_BYTES-1:0] reconfig_data,
  input  logic                  reconfig_data_en,
  input  logic                  bpi_idle,
  input  logic                  config_valid,
  output logic                  reconfig_read_start,
  output logic                  reconfig_read_end,
  output logic [7:0]            con_dout,
  output logic                  con_dout_en,
  input  logic                  con_dout_rdy,
  output logic [7:0]            reconfig_status,
  output logic [7:0]            reconfig_version1,
  output logic [15:0]           rec_cnt,
  output logic                  buf_overflow
);
  localparam int IW = 8*IN_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = $clog2(REC_LEN);
  localparam int SW = $clog2(IN_BYTES+1);
  typedef enum logic [1:0] {IDLE, START, DRAIN, CHECK} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] sh_q, sh_d;
  logic [SW-1:0] ser_q, ser_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, fill;
  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] top, wb, rd;
  logic [KW-1:0] k_q, k_d;
  logic [7:0] stat_q, stat_d, sum_q, sum_d, ver1_q, ver1_d, ver2_q, ver2_d, status_q, status_d;
  logic [15:0] exp_q, exp_d, rec_q, rec_d;
  logic cv_q, pend_q, pend_d, rs_q, rs_d, re_q, re_d, en_q, en_d, ov_q, ov_d;
  logic eor_q, eor_d, sent_q, sent_d, fail_q, fail_d, we, xfer, full;
  assign fill = wp_q - rp_q;
  assign full = fill == (AW+1)'(FIFO_DEPTH);
  assign top = sh_q[IW-1 -: 8];
  assign we = ser_q != '0 && !full;
  assign rd = mem[rp_q[AW-1:0]];
  assign xfer = en_q && con_dout_rdy;
  assign reconfig_read_start = rs_q;
  assign reconfig_read_end = re_q;
  assign con_dout = en_q ? rd : 8'h00;
  assign con_dout_en = en_q;
  assign reconfig_status = status_q;
  assign reconfig_version1 = ver1_q;
  assign rec_cnt = rec_q;
  assign buf_overflow = ov_q;
  always_comb begin
    for (int i = 0; i < 8; i++) wb[i] = BIT_REV != 0 ? top[7-i] : top[i];
  end
  always_ff @(posedge clk) begin
    if (we) mem[wp_q[AW-1:0]] <= wb;
  end
  always_comb begin
    state_d = state_q;
    sh_d = ser_q != '0 ? sh_q << 8 : sh_q;
    ser_d = ser_q != '0 ? ser_q - 1'b1 : ser_q;
    wp_d = we ? wp_q + 1'b1 : wp_q;
    rp_d = xfer ? rp_q + 1'b1 : rp_q;
    ov_d = ser_q != '0 && full;
    pend_d = pend_q | (config_valid & ~cv_q);
    k_d = k_q;
    stat_d = stat_q;
    sum_d = sum_q;
    ver1_d = ver1_q;
    ver2_d = ver2_q;
    status_d = status_q;
    exp_d = exp_q;
    rec_d = rec_q;
    eor_d = eor_q;
    sent_d = sent_q;
    fail_d = fail_q;
    rs_d = 1'b0;
    re_d = 1'b0;
    en_d = 1'b0;
    if (reconfig_data_en) begin
      if (ser_q == '0) begin
        sh_d = reconfig_data;
        ser_d = SW'(IN_BYTES);
      end else ov_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = START;
          pend_d = config_valid & ~cv_q;
        end else if (fill >= (AW+1)'(REC_LEN) && bpi_idle) begin
          state_d = DRAIN;
          rec_d = rec_q + 16'd1;
          k_d = '0;
          sum_d = 8'h00;
          stat_d = 8'h00;
          eor_d = 1'b0;
          sent_d = 1'b0;
          fail_d = 1'b0;
        end
      end
      START: begin
        state_d = IDLE;
        rs_d = 1'b1;
        status_d = 8'h00;
        rec_d = 16'h0000;
        ver1_d = 8'h00;
      end
      DRAIN: begin
        en_d = 1'b1;
        if (xfer) begin
          k_d = k_q + 1'b1;
          sum_d = sum_q + rd;
          if (k_q == KW'(3)) begin
            stat_d = rd;
            eor_d = rd == 8'h00;
            fail_d = fail_q | (rd > 8'(MAX_STAT));
            re_d = rd == 8'h00 || rd > 8'(MAX_STAT);
            sent_d = re_d;
          end
          if (k_q == KW'(4) && rd > stat_q) begin
            fail_d = 1'b1;
            re_d = !sent_q;
            sent_d = 1'b1;
          end
          if (rec_q == 16'd1 && k_q == KW'(6)) exp_d[15:8] = rd;
          if (rec_q == 16'd1 && k_q == KW'(7)) exp_d[7:0] = rd;
          if (rec_q == 16'd1 && k_q == KW'(8)) ver1_d = rd;
          if (eor_q && k_q == KW'(6)) ver2_d = rd;
          if (k_q == KW'(REC_LEN-1)) begin
            en_d = 1'b0;
            state_d = CHECK;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (fail_q || (CHK_EN != 0 && sum_q != 8'h00)) status_d = 8'h55;
        else if (eor_q) status_d = (exp_q + 16'd1 == rec_q && ver1_q == ver2_q) ? 8'hAA : 8'h55;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      ser_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      k_q <= '0;
      stat_q <= 8'h00;
      sum_q <= 8'h00;
      ver1_q <= 8'h00;
      ver2_q <= 8'h00;
      status_q <= 8'h00;
      exp_q <= 16'h0000;
      rec_q <= 16'h0000;
      cv_q <= 1'b0;
      pend_q <= 1'b0;
      rs_q <= 1'b0;
      re_q <= 1'b0;
      en_q <= 1'b0;
      ov_q <= 1'b0;
      eor_q <= 1'b0;
      sent_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      ser_q <= ser_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      k_q <= k_d;
      stat_q <= stat_d;
      sum_q <= sum_d;
      ver1_q <= ver1_d;
      ver2_q <= ver2_d;
      status_q <= status_d;
      exp_q <= exp_d;
      rec_q <= rec_d;
      cv_q <= config_valid;
      pend_q <= pend_d;
      rs_q <= rs_d;
      re_q <= re_d;
      en_q <= en_d;
      ov_q <= ov_d;
      eor_q <= eor_d;
      sent_q <= sent_d;
      fail_q <= fail_d;
    end
  end
endmodule
